font_access_arbiter: RTL

- Owns both ports of the 8Kx8 font BRAM and shares them between two requesters.
- Requester 1 is the video text fetch: fixed-priority, byte-wide, never stalled.
- Requester 2 is the host register interface: 16-bit word accesses, split into two sequenced byte accesses.
- Sits between the video generator, the bus register block and the font BRAM. Its font_* ports connect directly to the BRAM, which has 1-cycle read latency.

---
 rtl/font_pkg.sv | 20 ++
 rtl/font_access_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/font_pkg.sv
// Shared types and constants for the font BRAM access arbiter.
// Host words are big-endian: the high byte sits at the even byte address.
package font_pkg;

    localparam int   FONT_AW_DEFAULT = 13;
    localparam logic HI_FIRST        = 1'b1;
    localparam logic HI_OFS          = ~HI_FIRST;
    localparam logic LO_OFS          = HI_FIRST;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_HI   = 3'd1,
        ST_RD_LO   = 3'd2,
        ST_RD_LAST = 3'd3,
        ST_WR_HI   = 3'd4,
        ST_WR_LO   = 3'd5,
        ST_DONE    = 3'd6
    } font_state_e;

endpackage

// File: rtl/font_access_arbiter.sv
// Shares the dual-port font BRAM between the video fetch (read port priority)
// and the host register interface (16-bit words split into two byte accesses).
module font_access_arbiter
    import font_pkg::*;
#(
    parameter int FONT_AW = FONT_AW_DEFAULT,
    parameter int WAIT_W  = 8
) (
    input  logic               clk,
    input  logic               reset_n_i,
    input  logic               vid_rd_en_i,
    input  logic [FONT_AW-1:0] vid_addr_i,
    output logic [7:0]         vid_data_o,
    output logic               vid_valid_o,
    input  logic               host_req_i,
    input  logic               host_we_i,
    input  logic [FONT_AW-2:0] host_addr_i,
    input  logic [15:0]        host_wdata_i,
    output logic [15:0]        host_rdata_o,
    output logic               host_ack_o,
    output logic               host_busy_o,
    output logic [WAIT_W-1:0]  wait_cnt_o,
    output logic               font_rd_en_o,
    output logic [FONT_AW-1:0] font_rd_addr_o,
    input  logic [7:0]         font_rd_data_i,
    output logic               font_wr_en_o,
    output logic [FONT_AW-1:0] font_wr_addr_o,
    output logic [7:0]         font_wr_data_o
);

    font_state_e        state_r;
    font_state_e        state_s;
    logic [FONT_AW-2:0] addr_r;
    logic               we_r;
    logic [15:0]        wdata_r;
    logic [7:0]         data_hi_r;
    logic [15:0]        rdata_r;
    logic [WAIT_W-1:0]  wait_r;
    logic               vid_valid_r;
    logic               issued_r;
    logic               sel_r;

    logic               issue_s;
    logic               ofs_s;
    logic               block_s;
    logic               wr_en_s;
    logic               wr_ofs_s;
    logic [7:0]         wr_byte_s;

    // Next-state and per-state host access decode.
    always_comb begin
        state_s   = state_r;
        issue_s   = 1'b0;
        ofs_s     = HI_OFS;
        block_s   = 1'b0;
        wr_en_s   = 1'b0;
        wr_ofs_s  = HI_OFS;
        wr_byte_s = 8'h00;
        case (state_r)
            ST_IDLE: begin
                if (host_req_i) begin
                    state_s = host_we_i ? ST_WR_HI : ST_RD_HI;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RD_HI, ST_RD_LO: begin
                ofs_s = (state_r == ST_RD_HI) ? HI_OFS : LO_OFS;
                if (vid_rd_en_i) begin
                    block_s = 1'b1;
                end else begin
                    issue_s = 1'b1;
                    state_s = (state_r == ST_RD_HI) ? ST_RD_LO : ST_RD_LAST;
                end
            end
            ST_RD_LAST: begin
                state_s = ST_DONE;
            end
            ST_WR_HI: begin
                wr_en_s   = we_r;
                wr_byte_s = wdata_r[15:8];
                state_s   = ST_WR_LO;
            end
            ST_WR_LO: begin
                wr_en_s   = we_r;
                wr_ofs_s  = LO_OFS;
                wr_byte_s = wdata_r[7:0];
                state_s   = ST_DONE;
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // BRAM port drive: video always owns the read port when it asks.
    always_comb begin
        if (vid_rd_en_i) begin
            font_rd_en_o   = 1'b1;
            font_rd_addr_o = vid_addr_i;
        end else if (issue_s) begin
            font_rd_en_o   = 1'b1;
            font_rd_addr_o = {addr_r, ofs_s};
        end else begin
            font_rd_en_o   = 1'b0;
            font_rd_addr_o = {FONT_AW{1'b0}};
        end
        if (wr_en_s) begin
            font_wr_en_o   = 1'b1;
            font_wr_addr_o = {addr_r, wr_ofs_s};
            font_wr_data_o = wr_byte_s;
        end else begin
            font_wr_en_o   = 1'b0;
            font_wr_addr_o = {FONT_AW{1'b0}};
            font_wr_data_o = 8'h00;
        end
    end

    // State, request latch, wait counter and read-data capture registers.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r     <= ST_IDLE;
            addr_r      <= {(FONT_AW-1){1'b0}};
            we_r        <= 1'b0;
            wdata_r     <= 16'h0000;
            data_hi_r   <= 8'h00;
            rdata_r     <= 16'h0000;
            wait_r      <= {WAIT_W{1'b0}};
            vid_valid_r <= 1'b0;
            issued_r    <= 1'b0;
            sel_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            vid_valid_r <= vid_rd_en_i;
            issued_r    <= issue_s;
            sel_r       <= ofs_s;
            if ((state_r == ST_IDLE) && host_req_i) begin
                addr_r  <= host_addr_i;
                we_r    <= host_we_i;
                wdata_r <= host_wdata_i;
                wait_r  <= {WAIT_W{1'b0}};
            end else if (block_s && (wait_r != {WAIT_W{1'b1}})) begin
                wait_r <= wait_r + {{(WAIT_W-1){1'b0}}, 1'b1};
            end
            // BRAM data for a host issue arrives one cycle later; the low
            // byte completes the word straight into the held read register.
            if (issued_r && (sel_r == HI_OFS)) begin
                data_hi_r <= font_rd_data_i;
            end
            if (issued_r && (sel_r == LO_OFS)) begin
                rdata_r <= {data_hi_r, font_rd_data_i};
            end
        end
    end

    assign vid_data_o   = font_rd_data_i;
    assign vid_valid_o  = vid_valid_r;
    assign host_rdata_o = rdata_r;
    assign host_ack_o   = (state_r == ST_DONE);
    assign host_busy_o  = (state_r != ST_IDLE);
    assign wait_cnt_o   = wait_r;

endmodule
